// File: rtl/au_log2_pkg.sv
// Shared types and helpers for the fixed-point log2 unit.
package au_log2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  // max(ceil(log2 x), 1): bits needed to index x positions, never zero.
  function automatic int clogb2(input int x);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < x) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/au_log2_frac_int_log2.sv
// Combinational integer log2: position of the leading one (0 for a zero input).
module AU_int_log2
  import au_log2_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ARCH  = 0,
  localparam int IW   = clogb2(WIDTH)
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [IW-1:0]    e_o
);

  if (ARCH == 0) begin : g_up
    // Scan upward; the highest set bit is the last one written.
    always_comb begin
      e_o = '0;
      for (int i = 0; i < WIDTH; i++)
        if (a_i[i]) e_o = IW'(i);
    end
  end else begin : g_down
    logic found;
    // Scan downward and latch the first set bit seen.
    always_comb begin
      e_o   = '0;
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--)
        if (!found && a_i[i]) begin
          e_o   = IW'(i);
          found = 1'b1;
        end
    end
  end

endmodule

// File: rtl/au_log2_frac.sv
// Sequential fixed-point log2: integer part from the leading-one position,
// then one fractional bit per cycle by squaring the normalized mantissa.
module au_log2_frac
  import au_log2_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int ARCH  = 0,
  localparam int IW   = clogb2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  output logic               busy,
  output logic               done,
  output logic [IW+FRAC-1:0] z,
  output logic               err
);

  localparam int CW = clogb2(FRAC + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW+FRAC-1:0] z_q, z_d;
  logic               err_q, err_d;
  logic               busy_q, done_q;
  logic [IW-1:0]      e;
  logic [2*WIDTH-1:0] p;
  logic               bitv;
  logic               unused_p;

  AU_int_log2 #(.WIDTH(WIDTH), .ARCH(ARCH)) u_int_log2 (
    .a_i (a),
    .e_o (e)
  );

  // Mantissa is 1.f with WIDTH-1 fraction bits, so p is in [1,4).
  assign p        = {{WIDTH{1'b0}}, m_q} * {{WIDTH{1'b0}}, m_q};
  assign bitv     = p[2*WIDTH-1];
  // Bits below the renormalized window are truncated away.
  assign unused_p = ^p[WIDTH-2:0];

  // Next-state: accept in IDLE, refine one bit per ITER cycle, pulse DONE.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start) begin
        if (a != '0) begin
          m_d     = a << (IW'(WIDTH - 1) - e);
          z_d     = {e, {FRAC{1'b0}}};
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ITER;
        end else begin
          z_d     = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      ITER: begin
        // Squared value >= 2 means the next fraction bit is 1; halve to renormalize.
        m_d = bitv ? p[2*WIDTH-1:WIDTH] : p[2*WIDTH-2:WIDTH-1];
        for (int i = 0; i < FRAC; i++)
          if (cnt_q == CW'(FRAC - 1 - i)) z_d[i] = bitv;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(FRAC - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      err_q   <= err_d;
      busy_q  <= (state_d == ITER);
      done_q  <= (state_d == DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign z    = z_q;
  assign err  = err_q;

endmodule
